// File: rtl/fp_pkg.sv
// Shared constants and types for the sequential single-precision adder.
// Holds the IEEE field widths, the special result encodings, the FSM state
// enum and the bit positions of the status flags in out_flags.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int WORD_W  = 1 + EXP_W + MAN_W;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    // Aligned fraction: {hidden, mantissa, guard, round, sticky}
    localparam int FRAC_W  = MAN_W + 4;
    // Adder result adds one carry bit on top of the aligned fraction
    localparam int SUM_W   = FRAC_W + 1;

    localparam logic [WORD_W-1:0] QNAN = 32'h7FC0_0000;

    localparam int FLAG_INVALID   = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter for the 28-bit adder result.
// Ports:
//   value_i  28-bit value to scan, bit 27 is the most significant
//   count_o  number of zeros above the highest set bit (28 when value_i is 0)
module fp_lzc
    import fp_pkg::*;
(
    input  logic [SUM_W-1:0] value_i,
    output logic [4:0]       count_o
);

    // Scanning upward lets the highest set bit be the last one to win.
    always_comb begin
        count_o = 5'(SUM_W);
        for (int i = 0; i < SUM_W; i++) begin
            if (value_i[i]) begin
                count_o = 5'(SUM_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp32_add_seq.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor, round toward zero.
// Walks IDLE -> ALIGN -> ADD -> NORM -> DONE, one state per clock.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake (ready only in IDLE)
//   in_a, in_b, in_sub   operands; in_sub=1 computes A-B
//   out_valid/out_ready  result handshake (valid only in DONE)
//   out_sum, out_flags   result word and {invalid, overflow, underflow}
module fp32_add_seq
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic [2:0]        out_flags
);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   a_q, b_q;
    logic                sign_q, effSub_q;
    logic [EXP_W-1:0]    exp_q;
    logic [FRAC_W-1:0]   xFrac_q, yFrac_q;
    logic [SUM_W-1:0]    sum_q;
    logic                spec_q, specInv_q;
    logic [WORD_W-1:0]   specSum_q;
    logic [WORD_W-1:0]   resSum_q;
    logic [2:0]          resFlags_q;

    logic                aZero, bZero, aInf, bInf, aNan, bNan, aBig;
    logic                xSign;
    logic [EXP_W-1:0]    xExp, yExp, expDiff;
    logic [MAN_W-1:0]    xMan, yMan;
    logic [FRAC_W-1:0]   yFull, yLost, yShift;
    logic                specHit, specInv;
    logic [WORD_W-1:0]   specSum;

    logic [4:0]          lzCount, normShift;
    logic [SUM_W-1:0]    normFrac;
    logic signed [EXP_W+1:0] normExp;
    logic [WORD_W-1:0]   normSum;
    logic [2:0]          normFlags;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = resSum_q;
    assign out_flags = resFlags_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Unpack, order by magnitude and align the smaller operand. Denormals
    // count as zero, so only normal finite pairs reach the fraction path.
    always_comb begin
        aZero = (a_q[MAN_W +: EXP_W] == '0);
        bZero = (b_q[MAN_W +: EXP_W] == '0);
        aInf  = (a_q[MAN_W +: EXP_W] == '1) && (a_q[MAN_W-1:0] == '0);
        bInf  = (b_q[MAN_W +: EXP_W] == '1) && (b_q[MAN_W-1:0] == '0);
        aNan  = (a_q[MAN_W +: EXP_W] == '1) && (a_q[MAN_W-1:0] != '0);
        bNan  = (b_q[MAN_W +: EXP_W] == '1) && (b_q[MAN_W-1:0] != '0);
        // Exponent sits above mantissa, so the magnitude compares as an integer
        aBig  = (a_q[WORD_W-2:0] >= b_q[WORD_W-2:0]);

        xSign = aBig ? a_q[WORD_W-1] : b_q[WORD_W-1];
        xExp  = aBig ? a_q[MAN_W +: EXP_W] : b_q[MAN_W +: EXP_W];
        yExp  = aBig ? b_q[MAN_W +: EXP_W] : a_q[MAN_W +: EXP_W];
        xMan  = aBig ? a_q[MAN_W-1:0] : b_q[MAN_W-1:0];
        yMan  = aBig ? b_q[MAN_W-1:0] : a_q[MAN_W-1:0];

        expDiff = xExp - yExp;
        yFull   = {1'b1, yMan, 3'b000};
        yLost   = '0;
        if (expDiff >= EXP_W'(FRAC_W)) begin
            // Everything slides past the sticky position; the hidden bit alone makes it 1
            yShift = FRAC_W'(1);
        end else begin
            yLost     = yFull & ((FRAC_W'(1) << expDiff) - FRAC_W'(1));
            yShift    = yFull >> expDiff;
            yShift[0] = yShift[0] | (|yLost);
        end

        specHit = 1'b1;
        specInv = 1'b0;
        specSum = '0;
        if (aNan || bNan) begin
            specSum = QNAN;
            specInv = 1'b1;
        end else if (aInf && bInf) begin
            if (a_q[WORD_W-1] != b_q[WORD_W-1]) begin
                specSum = QNAN;
                specInv = 1'b1;
            end else begin
                specSum = a_q;
            end
        end else if (aInf) begin
            specSum = a_q;
        end else if (bInf) begin
            specSum = b_q;
        end else if (aZero && bZero) begin
            specSum = {a_q[WORD_W-1] & b_q[WORD_W-1], {(WORD_W-1){1'b0}}};
        end else if (aZero) begin
            specSum = b_q;
        end else if (bZero) begin
            specSum = a_q;
        end else begin
            specHit = 1'b0;
        end
    end

    fp_lzc u_lzc (
        .value_i (sum_q),
        .count_o (lzCount)
    );

    // Bring the leading one back to the hidden position (bit 26), then
    // truncate guard/round/sticky and range-check the exponent.
    always_comb begin
        normShift = lzCount - 5'd1;
        normFrac  = sum_q << normShift;
        normExp   = $signed({2'b00, exp_q}) - $signed({5'b00000, normShift});
        if (sum_q[SUM_W-1]) begin
            normFrac = {1'b0, sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
            normExp  = $signed({2'b00, exp_q}) + 10'sd1;
        end

        normFlags = '0;
        if (spec_q) begin
            normSum = specSum_q;
            normFlags[FLAG_INVALID] = specInv_q;
        end else if (sum_q == '0) begin
            normSum = '0;
        end else if (normExp >= EXP_MAX) begin
            normSum = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            normFlags[FLAG_OVERFLOW] = 1'b1;
        end else if (normExp <= 0) begin
            normSum = {sign_q, {(WORD_W-1){1'b0}}};
            normFlags[FLAG_UNDERFLOW] = 1'b1;
        end else begin
            normSum = {sign_q, normExp[EXP_W-1:0], normFrac[FRAC_W-2:3]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            effSub_q   <= 1'b0;
            exp_q      <= '0;
            xFrac_q    <= '0;
            yFrac_q    <= '0;
            sum_q      <= '0;
            spec_q     <= 1'b0;
            specInv_q  <= 1'b0;
            specSum_q  <= '0;
            resSum_q   <= '0;
            resFlags_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= in_a;
                        b_q        <= {in_b[WORD_W-1] ^ in_sub, in_b[WORD_W-2:0]};
                        resFlags_q <= '0;
                    end
                end
                ALIGN: begin
                    sign_q    <= xSign;
                    effSub_q  <= a_q[WORD_W-1] ^ b_q[WORD_W-1];
                    exp_q     <= xExp;
                    xFrac_q   <= {1'b1, xMan, 3'b000};
                    yFrac_q   <= yShift;
                    spec_q    <= specHit;
                    specInv_q <= specInv;
                    specSum_q <= specSum;
                end
                ADD: begin
                    sum_q <= effSub_q ? ({1'b0, xFrac_q} - {1'b0, yFrac_q})
                                      : ({1'b0, xFrac_q} + {1'b0, yFrac_q});
                end
                NORM: begin
                    resSum_q   <= normSum;
                    resFlags_q <= normFlags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_add_seq.sv
// Scoreboard bench for fp32_add_seq: the driver pushes hand-computed results
// into a queue and a monitor pops and compares on every result handshake.
module tb_fp32_add_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [2:0]  out_flags;

    typedef struct {
        logic [31:0] sum;
        logic [2:0]  flags;
        int          acceptEdge;
        bit          checkLat;
        string       name;
    } expect_t;

    expect_t expQ[$];
    int      checks = 0;
    int      passes = 0;
    int      edgeCount = 0;

    fp32_add_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic failTimeout(input string name);
        checks++;
        $display("[TB] FAIL %s: got timeout, required DUT response", name);
    endtask

    // Monitor: samples just after the falling edge so driver inputs are settled.
    always @(negedge clk) begin
        expect_t e;
        #1;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpectedOutput: got sum %h, required no output", out_sum);
            end else begin
                e = expQ.pop_front();
                checkOutput({e.name, ".sum"}, out_sum, e.sum);
                checkOutput({e.name, ".flags"}, {29'd0, out_flags}, {29'd0, e.flags});
                if (e.checkLat)
                    checkOutput({e.name, ".latency"}, 32'(edgeCount + 1 - e.acceptEdge), 32'd4);
            end
        end
    end

    task automatic waitIdle(input string name);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) failTimeout({name, ".waitIdle"});
    endtask

    // Called at a falling edge; issues one operation and queues its result.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                 input logic [31:0] expSum, input logic [2:0] expFlags,
                                 input string name);
        expect_t e;
        int n;
        waitIdle(name);
        in_a = a;
        in_b = b;
        in_sub = sub;
        in_valid = 1'b1;
        e.sum = expSum;
        e.flags = expFlags;
        e.acceptEdge = edgeCount + 1;
        e.checkLat = out_ready;
        e.name = name;
        expQ.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        if (out_ready) begin
            n = 0;
            while (out_valid !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (out_valid !== 1'b1) begin
                failTimeout({name, ".outValid"});
            end else begin
                @(negedge clk);
                checkOutput({name, ".validOneCycle"}, {31'd0, out_valid}, 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_sub = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset.outValid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset.inReady", {31'd0, in_ready}, 32'd1);
        checkOutput("reset.outSum", out_sum, 32'd0);
        checkOutput("reset.outFlags", {29'd0, out_flags}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, "onePlusTwo");
        applyStimulus(32'h40A00000, 32'hC0A00000, 1'b0, 32'h00000000, 3'b000, "cancel");
        applyStimulus(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, "negZeros");
        applyStimulus(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000, "tinyAdd");
        applyStimulus(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000, "tinySub");
        applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010, "overflow");
        applyStimulus(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100, "infMinusInf");
        applyStimulus(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, "nanIn");
        applyStimulus(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000, "infPlusOne");
        applyStimulus(32'h00000000, 32'hC0400000, 1'b0, 32'hC0400000, 3'b000, "zeroPlusX");
        applyStimulus(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, "threeMinusOne");
        applyStimulus(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001, "underflow");

        // Backpressure: result must hold in DONE and a second request is ignored
        out_ready = 1'b0;
        applyStimulus(32'h40A00000, 32'h40A00000, 1'b0, 32'h41200000, 3'b000, "backpressure");
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (out_valid !== 1'b1) failTimeout("bp.outValid");
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp.holdSum", out_sum, 32'h41200000);
            checkOutput("bp.holdFlags", {29'd0, out_flags}, 32'd0);
            checkOutput("bp.inReady", {31'd0, in_ready}, 32'd0);
            checkOutput("bp.outValid", {31'd0, out_valid}, 32'd1);
            in_a = 32'h3F800000;
            in_b = 32'h3F800000;
            in_sub = 1'b0;
            in_valid = (i == 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp.releaseInReady", {31'd0, in_ready}, 32'd1);
        checkOutput("bp.releaseOutValid", {31'd0, out_valid}, 32'd0);
        repeat (8) @(negedge clk);

        // Reset while the operation sits in ADD: nothing may come out
        waitIdle("midReset");
        in_a = 32'h3F800000;
        in_b = 32'h40000000;
        in_sub = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midReset.outValid", {31'd0, out_valid}, 32'd0);
        checkOutput("midReset.outSum", out_sum, 32'd0);
        checkOutput("midReset.outFlags", {29'd0, out_flags}, 32'd0);
        checkOutput("midReset.inReady", {31'd0, in_ready}, 32'd1);
        repeat (10) @(negedge clk);

        applyStimulus(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, "afterReset");
        repeat (5) @(negedge clk);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
